// File: rtl/r_release_ctrl.sv
// r_release_ctrl: in-order burst release from the per-UID park with ID restore,
// registered R output stage, UID return and burst length checking.
module r_release_ctrl #(
  parameter int NUM_UIDS      = 16,
  parameter int ID_WIDTH      = $clog2(NUM_UIDS),
  parameter int ORIG_ID_WIDTH = 4,
  parameter int LEN_WIDTH     = 8,
  parameter int DATA_WIDTH    = 64,
  parameter int RESP_WIDTH    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic [ID_WIDTH-1:0]      issue_uid,
  input  logic [ORIG_ID_WIDTH-1:0] issue_orig_id,
  input  logic [LEN_WIDTH-1:0]     issue_len,
  output logic                     free_req,
  output logic [ID_WIDTH-1:0]      uid_to_free,
  input  logic                     park_valid,
  input  logic [DATA_WIDTH-1:0]    park_data,
  input  logic [RESP_WIDTH-1:0]    park_resp,
  input  logic                     park_last,
  output logic                     park_ready,
  input  logic                     free_ack,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [ORIG_ID_WIDTH-1:0] m_id,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic [RESP_WIDTH-1:0]    m_resp,
  output logic                     m_last,
  output logic                     uid_release_valid,
  output logic [ID_WIDTH-1:0]      uid_release,
  output logic                     len_err
);
  localparam int CW = $clog2(NUM_UIDS + 1);

  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_nx;

  logic [ID_WIDTH-1:0]      uid_q [NUM_UIDS];
  logic [ORIG_ID_WIDTH-1:0] oid_q [NUM_UIDS];
  logic [LEN_WIDTH-1:0]     len_q [NUM_UIDS];
  logic [ID_WIDTH-1:0]      head, tail;
  logic [CW-1:0]            count, count_nx;
  logic [LEN_WIDTH:0]       beat_cnt, len_ext;
  logic                     push, pop, stream;

  function automatic logic [ID_WIDTH-1:0] nxt(input logic [ID_WIDTH-1:0] p);
    return (p == ID_WIDTH'(NUM_UIDS - 1)) ? '0 : p + ID_WIDTH'(1);
  endfunction

  assign stream      = (state == STREAM);
  assign issue_ready = (count != CW'(NUM_UIDS));
  assign push        = issue_valid & issue_ready;
  assign pop         = free_ack & park_last;
  assign free_req    = stream;
  assign uid_to_free = stream ? uid_q[head] : '0;
  assign park_ready  = stream & (!m_valid | m_ready);
  assign len_ext     = {1'b0, len_q[head]};

  // Next state follows the post-update count so a push shows up as free_req one cycle later.
  always_comb begin
    count_nx = count + CW'(push) - CW'(pop);
    state_nx = (count_nx != '0) ? STREAM : IDLE;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      uid_q[tail] <= issue_uid;
      oid_q[tail] <= issue_orig_id;
      len_q[tail] <= issue_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      count             <= '0;
      head              <= '0;
      tail              <= '0;
      beat_cnt          <= '0;
      m_valid           <= 1'b0;
      m_id              <= '0;
      m_data            <= '0;
      m_resp            <= '0;
      m_last            <= 1'b0;
      uid_release_valid <= 1'b0;
      uid_release       <= '0;
      len_err           <= 1'b0;
    end else begin
      state             <= state_nx;
      count             <= count_nx;
      if (push) tail <= nxt(tail);
      if (pop) head <= nxt(head);
      beat_cnt          <= pop ? '0 : free_ack ? beat_cnt + (LEN_WIDTH+1)'(1) : beat_cnt;
      m_valid           <= free_ack | (m_valid & !m_ready);
      if (free_ack) begin
        m_id   <= oid_q[head];
        m_data <= park_data;
        m_resp <= park_resp;
        m_last <= park_last;
      end
      uid_release_valid <= pop;
      uid_release       <= pop ? uid_q[head] : '0;
      // Early last, or a non-last beat where the final one was due.
      if (free_ack & (park_last ? (beat_cnt != len_ext) : (beat_cnt == len_ext))) len_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_r_release_ctrl.sv
// tb_r_release_ctrl: bench acts as the park and the master; a burst-order
// reference model predicts every released beat, UID return and length error.
module tb_r_release_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0, issue_ready;
  logic [3:0]  issue_uid = '0, issue_orig_id = '0;
  logic [7:0]  issue_len = '0;
  logic        free_req, park_valid, park_last, park_ready, free_ack;
  logic [3:0]  uid_to_free;
  logic [63:0] park_data;
  logic [1:0]  park_resp;
  logic        m_valid, m_ready = 1'b1, m_last;
  logic [3:0]  m_id;
  logic [63:0] m_data;
  logic [1:0]  m_resp;
  logic        uid_release_valid, len_err;
  logic [3:0]  uid_release;

  always #5 clk = ~clk;

  r_release_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_uid(issue_uid),
    .issue_orig_id(issue_orig_id), .issue_len(issue_len),
    .free_req(free_req), .uid_to_free(uid_to_free),
    .park_valid(park_valid), .park_data(park_data), .park_resp(park_resp),
    .park_last(park_last), .park_ready(park_ready), .free_ack(free_ack),
    .m_valid(m_valid), .m_ready(m_ready), .m_id(m_id), .m_data(m_data),
    .m_resp(m_resp), .m_last(m_last),
    .uid_release_valid(uid_release_valid), .uid_release(uid_release), .len_err(len_err)
  );

  // Park model: per-UID beat store, supplied count vs popped count.
  logic [63:0] dmem [16][64];
  logic        lmem [16][64];
  int          avail [16];
  int          taken [16];
  logic [5:0]  rd_idx;
  assign rd_idx     = 6'(taken[uid_to_free]);
  assign park_valid = free_req && (avail[uid_to_free] != taken[uid_to_free]);
  assign park_data  = dmem[uid_to_free][rd_idx];
  assign park_resp  = park_data[1:0];
  assign park_last  = lmem[uid_to_free][rd_idx];
  assign free_ack   = park_valid & park_ready;

  typedef struct {logic [3:0] uid; logic [3:0] oid; logic [7:0] len;} burst_t;
  burst_t     ord_q [$];
  logic [3:0] rel_q [$];
  int         mcons [16];
  bit         inflight [16];
  int         mcnt, outcnt, cyc, last_ack;
  bit         exp_err, pushed;
  logic [3:0] pend_u [$];
  int         pend_n [$];
  int         checks, errors;

  typedef struct {int uid; int oid; int len; int nb; bit stall; bit exp_err;} vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic supply(input logic [3:0] u, input int n);
    logic [5:0] idx;
    for (int k = 0; k < n; k++) begin
      idx = 6'(avail[u]);
      dmem[u][idx] = {$urandom, $urandom};
      lmem[u][idx] = (k == n - 1);
      avail[u]++;
    end
  endtask

  // Oldest unfinished burst owns the next output beat; its next parked beat is the data.
  task automatic check_out;
    burst_t     h;
    logic [5:0] s;
    if (ord_q.size() == 0) begin
      chk("unexpected_beat", 64'(m_valid), 64'(0));
      return;
    end
    h = ord_q[0];
    s = 6'(mcons[h.uid]);
    chk("m_id", 64'(m_id), 64'(h.oid));
    chk("m_data", m_data, dmem[h.uid][s]);
    chk("m_resp", 64'(m_resp), 64'(dmem[h.uid][s][1:0]));
    chk("m_last", 64'(m_last), 64'(lmem[h.uid][s]));
    mcons[h.uid]++;
    mcnt++;
    outcnt++;
    if (lmem[h.uid][s]) begin
      if (mcnt != int'(h.len) + 1) exp_err = 1'b1;
      mcnt = 0;
      void'(ord_q.pop_front());
    end
  endtask

  task automatic tick;
    logic       ack, lst;
    logic [3:0] u;
    #3;
    ack = free_ack;
    lst = park_last;
    u = uid_to_free;
    pushed = 1'b0;
    if (issue_valid && issue_ready) begin
      ord_q.push_back('{issue_uid, issue_orig_id, issue_len});
      rel_q.push_back(issue_uid);
      inflight[issue_uid] = 1'b1;
      pushed = 1'b1;
    end
    if (m_valid && m_ready) check_out();
    if (uid_release_valid) begin
      if (rel_q.size() == 0) chk("spurious_release", 64'(uid_release_valid), 64'(0));
      else chk("uid_release", 64'(uid_release), 64'(rel_q.pop_front()));
      chk("release_timing", 64'(cyc), 64'(last_ack + 1));
      inflight[uid_release] = 1'b0;
    end
    if (ack && lst) last_ack = cyc;
    @(posedge clk);
    #1;
    cyc++;
    if (ack) taken[u]++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    issue_valid = 1'b0;
    m_ready = 1'b1;
    while (pend_u.size() != 0) supply(pend_u.pop_front(), pend_n.pop_front());
    while (ord_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (ord_q.size() != 0) chk("drain_timeout", 64'(ord_q.size()), 64'(0));
    tick();
    tick();
    chk("release_pending", 64'(rel_q.size()), 64'(0));
  endtask

  task automatic issue(input logic [3:0] u, input logic [3:0] o, input logic [7:0] l);
    issue_valid = 1'b1;
    issue_uid = u;
    issue_orig_id = o;
    issue_len = l;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic rst_chk;
    chk("rst_issue_ready", 64'(issue_ready), 64'(1));
    chk("rst_free_req", 64'(free_req), 64'(0));
    chk("rst_uid_to_free", 64'(uid_to_free), 64'(0));
    chk("rst_park_ready", 64'(park_ready), 64'(0));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_m_id", 64'(m_id), 64'(0));
    chk("rst_m_data", m_data, 64'(0));
    chk("rst_m_resp", 64'(m_resp), 64'(0));
    chk("rst_m_last", 64'(m_last), 64'(0));
    chk("rst_rel_valid", 64'(uid_release_valid), 64'(0));
    chk("rst_rel_uid", 64'(uid_release), 64'(0));
    chk("rst_len_err", 64'(len_err), 64'(0));
  endtask

  initial begin
    logic [63:0] d0;
    int          b0, n;
    logic [3:0]  u;
    logic [7:0]  l;
    checks = 0; errors = 0; cyc = 0; last_ack = -10; mcnt = 0; outcnt = 0; exp_err = 1'b0;
    for (int i = 0; i < 16; i++) begin
      avail[i] = 0; taken[i] = 0; mcons[i] = 0; inflight[i] = 1'b0;
      for (int j = 0; j < 64; j++) begin
        dmem[i][j] = '0;
        lmem[i][j] = 1'b0;
      end
    end
    vt[0] = '{3, 5, 3, 4, 1'b1, 1'b0};
    vt[1] = '{1, 9, 0, 1, 1'b0, 1'b0};
    vt[2] = '{15, 15, 7, 8, 1'b1, 1'b0};
    vt[3] = '{0, 0, 2, 3, 1'b0, 1'b0};
    vt[4] = '{4, 2, 1, 1, 1'b0, 1'b1};
    vt[5] = '{6, 3, 0, 2, 1'b0, 1'b1};

    #12;
    rst_chk();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      chk("free_req_idle", 64'(free_req), 64'(0));
      issue(4'(vt[i].uid), 4'(vt[i].oid), 8'(vt[i].len));
      chk("issue_push", 64'(pushed), 64'(1));
      chk("free_req_latency", 64'(free_req), 64'(1));
      chk("uid_to_free", 64'(uid_to_free), 64'(vt[i].uid));
      b0 = outcnt;
      supply(4'(vt[i].uid), vt[i].nb);
      if (vt[i].stall) begin
        tick();
        tick();
        m_ready = 1'b0;
        d0 = m_data;
        chk("stall_m_valid", 64'(m_valid), 64'(1));
        for (int k = 0; k < 5; k++) begin
          tick();
          chk("stall_park_ready", 64'(park_ready), 64'(0));
          chk("stall_free_ack", 64'(free_ack), 64'(0));
          chk("stall_m_data", m_data, d0);
        end
      end
      drain(100);
      chk("burst_beats", 64'(outcnt - b0), 64'(vt[i].nb));
      chk("len_err", 64'(len_err), 64'(vt[i].exp_err));
    end

    // In-order release even when the younger burst is parked first.
    issue(4'd2, 4'hA, 8'd0);
    issue(4'd7, 4'hB, 8'd0);
    supply(4'd7, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("order_free_req", 64'(free_req), 64'(1));
      chk("order_head_uid", 64'(uid_to_free), 64'(2));
      chk("order_no_output", 64'(m_valid), 64'(0));
    end
    supply(4'd2, 1);
    drain(50);

    // Fill the order FIFO, refuse a 17th issue, reopen after one completion.
    for (int k = 0; k < 16; k++) issue(4'(k), 4'(15 - k), 8'd0);
    chk("full_issue_ready", 64'(issue_ready), 64'(0));
    issue(4'd0, 4'd1, 8'd0);
    chk("full_refused", 64'(pushed), 64'(0));
    chk("full_depth", 64'(ord_q.size()), 64'(16));
    supply(4'd0, 1);
    tick();
    chk("reopen_issue_ready", 64'(issue_ready), 64'(1));
    for (int k = 1; k < 16; k++) begin
      pend_u.push_back(4'(k));
      pend_n.push_back(1);
    end
    drain(100);

    // Reset mid-burst discards everything and clears the sticky error.
    issue(4'd5, 4'd6, 8'd3);
    supply(4'd5, 4);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    rst_chk();
    ord_q.delete();
    rel_q.delete();
    for (int i = 0; i < 16; i++) begin
      avail[i] = taken[i];
      mcons[i] = taken[i];
      inflight[i] = 1'b0;
    end
    mcnt = 0;
    exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(4'd5, 4'd7, 8'd1);
    supply(4'd5, 2);
    drain(50);
    chk("post_reset_len_err", 64'(len_err), 64'(0));

    // Random traffic: any issue/supply order, random master backpressure.
    for (int c = 0; c < 1500; c++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      issue_valid = 1'b0;
      u = 4'($urandom_range(0, 15));
      l = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0 && !inflight[u]) begin
        issue_valid = 1'b1;
        issue_uid = u;
        issue_orig_id = 4'($urandom);
        issue_len = l;
      end
      if (pend_u.size() != 0 && $urandom_range(0, 2) == 0) begin
        n = $urandom_range(0, pend_u.size() - 1);
        supply(pend_u[n], pend_n[n]);
        pend_u.delete(n);
        pend_n.delete(n);
      end
      tick();
      issue_valid = 1'b0;
      if (pushed) begin
        n = int'(l) + 1;
        case ($urandom_range(0, 9))
          0: n = n + 1;
          1: if (l != 0) n = n - 1;
          default: ;
        endcase
        pend_u.push_back(u);
        pend_n.push_back(n);
      end
    end
    drain(500);
    chk("random_len_err", 64'(len_err), 64'(exp_err));
    chk("random_idle", 64'(free_req), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
